uart_loader: RTL and testbench



---
 rtl/uart_loader_if.sv | 24 ++
 rtl/uart_loader.sv | 164 ++++++++++++++++
 tb/tb_uart_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
`default_nettype none
// uart_loader_if: UART receive byte stream into the loader, memory-write port and status out of it.
interface uart_loader_if;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;

   modport slave (
      input  rx_dv, rx_byte,
      output mem_addr, mem_data, mem_we, busy, done, error, err_code
   );

   modport master (
      output rx_dv, rx_byte,
      input  mem_addr, mem_data, mem_we, busy, done, error, err_code
   );
endinterface
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// uart_loader: parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream,
// streams payload bytes to a memory write port, verifies the checksum and aborts stalled frames.
module uart_loader #(
   parameter int unsigned TIMEOUT_CLKS = 8680,
   parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
   input  logic         i_Clock,
   input  logic         i_Rst_L,
   uart_loader_if.slave bus
);
   localparam int unsigned   TW       = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [1:0]    ERR_OK   = 2'b00;
   localparam logic [1:0]    ERR_CHK  = 2'b01;
   localparam logic [1:0]    ERR_TMO  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR_HI = 3'd1,
      S_ADDR_LO = 3'd2,
      S_LEN     = 3'd3,
      S_DATA    = 3'd4,
      S_CHK     = 3'd5
   } state_t;

   state_t        state,    state_nxt;
   logic [15:0]   addr,     addr_nxt;
   logic [8:0]    remain,   remain_nxt;
   logic [7:0]    sum,      sum_nxt;
   logic [TW-1:0] tmo_cnt,  tmo_nxt;
   logic [15:0]   mem_addr, mem_addr_nxt;
   logic [7:0]    mem_data, mem_data_nxt;
   logic          mem_we,   mem_we_nxt;
   logic          done,     done_nxt;
   logic          error,    error_nxt;
   logic [1:0]    err_code, err_code_nxt;
   logic [7:0]    sum_with_byte;

   assign sum_with_byte = sum + bus.rx_byte;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state    <= S_IDLE;
         addr     <= '0;
         remain   <= '0;
         sum      <= '0;
         tmo_cnt  <= '0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_code <= ERR_OK;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         remain   <= remain_nxt;
         sum      <= sum_nxt;
         tmo_cnt  <= tmo_nxt;
         mem_addr <= mem_addr_nxt;
         mem_data <= mem_data_nxt;
         mem_we   <= mem_we_nxt;
         done     <= done_nxt;
         error    <= error_nxt;
         err_code <= err_code_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      remain_nxt   = remain;
      sum_nxt      = sum;
      tmo_nxt      = '0;
      mem_addr_nxt = mem_addr;
      mem_data_nxt = mem_data;
      mem_we_nxt   = 1'b0;
      done_nxt     = 1'b0;
      error_nxt    = 1'b0;
      err_code_nxt = err_code;

      if (state != S_IDLE && !bus.rx_dv) begin
         tmo_nxt = tmo_cnt + 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (bus.rx_dv && bus.rx_byte == SYNC_BYTE) begin
               err_code_nxt = ERR_OK;
               sum_nxt      = '0;
               state_nxt    = S_ADDR_HI;
            end
         end
         S_ADDR_HI: begin
            if (bus.rx_dv) begin
               addr_nxt[15:8] = bus.rx_byte;
               sum_nxt        = sum_with_byte;
               state_nxt      = S_ADDR_LO;
            end
         end
         S_ADDR_LO: begin
            if (bus.rx_dv) begin
               addr_nxt[7:0] = bus.rx_byte;
               sum_nxt       = sum_with_byte;
               state_nxt     = S_LEN;
            end
         end
         S_LEN: begin
            if (bus.rx_dv) begin
               // A zero length byte encodes a full 256-byte payload.
               remain_nxt = (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
               sum_nxt    = sum_with_byte;
               state_nxt  = S_DATA;
            end
         end
         S_DATA: begin
            if (bus.rx_dv) begin
               mem_we_nxt   = 1'b1;
               mem_addr_nxt = addr;
               mem_data_nxt = bus.rx_byte;
               addr_nxt     = addr + 16'd1;
               remain_nxt   = remain - 9'd1;
               sum_nxt      = sum_with_byte;
               if (remain == 9'd1) begin
                  state_nxt = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (bus.rx_dv) begin
               if (sum_with_byte == 8'h00) begin
                  done_nxt     = 1'b1;
                  err_code_nxt = ERR_OK;
               end else begin
                  error_nxt    = 1'b1;
                  err_code_nxt = ERR_CHK;
               end
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // A byte arriving on the terminal-count cycle keeps the frame alive.
      if (state != S_IDLE && !bus.rx_dv && tmo_cnt == TMO_LAST) begin
         state_nxt    = S_IDLE;
         tmo_nxt      = '0;
         error_nxt    = 1'b1;
         err_code_nxt = ERR_TMO;
      end
   end

   assign bus.mem_addr = mem_addr;
   assign bus.mem_data = mem_data;
   assign bus.mem_we   = mem_we;
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = done;
   assign bus.error    = error;
   assign bus.err_code = err_code;
endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// tb_uart_loader: directed and randomized frames checked against a frame-level reference model.
module tb_uart_loader;
   localparam int         TMO  = 100;
   localparam logic [7:0] SYNC = 8'h55;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_loader_if bus();

   uart_loader #(
      .TIMEOUT_CLKS(TMO),
      .SYNC_BYTE   (SYNC)
   ) dut (
      .i_Clock(clk),
      .i_Rst_L(rst_n),
      .bus    (bus)
   );

   int         tests    = 0;
   int         fails    = 0;
   int         we_count = 0;
   bit         overlap  = 1'b0;
   logic [7:0] pl [256];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) we_count++;
      if (bus.done === 1'b1 && bus.error === 1'b1) overlap = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_dv   = 1'b1;
      bus.rx_byte = b;
      @(negedge clk);
      bus.rx_dv   = 1'b0;
      bus.rx_byte = 8'($urandom);
   endtask

   // Reference model: the expected checksum, write list and result are derived
   // from the frame contents in pl[0..len-1]; len is 1..256.
   task automatic send_frame(input logic [15:0] base, input int len, input bit bad);
      logic [7:0] lenb, s, chkb;
      int         w0;
      lenb = 8'(len);
      s    = base[15:8] + base[7:0] + lenb;
      for (int i = 0; i < len; i++) s = s + pl[i];
      chkb = 8'h00 - s;
      if (bad) chkb = chkb + 8'h01;
      w0 = we_count;

      send_byte(SYNC);
      chk("sync_busy", bus.busy, 1);
      chk("sync_code", bus.err_code, 0);
      idle($urandom_range(0, 3));
      send_byte(base[15:8]);
      idle($urandom_range(0, 3));
      send_byte(base[7:0]);
      idle($urandom_range(0, 3));
      send_byte(lenb);
      chk("hdr_no_we", bus.mem_we, 0);
      for (int i = 0; i < len; i++) begin
         idle($urandom_range(0, 3));
         send_byte(pl[i]);
         chk("wr_we",   bus.mem_we, 1);
         chk("wr_addr", bus.mem_addr, 32'(16'(base + 16'(i))));
         chk("wr_data", bus.mem_data, pl[i]);
      end
      idle($urandom_range(0, 3));
      send_byte(chkb);
      chk("end_done",  bus.done,  bad ? 0 : 1);
      chk("end_error", bus.error, bad ? 1 : 0);
      chk("end_code",  bus.err_code, bad ? 1 : 0);
      chk("end_busy",  bus.busy, 0);
      chk("end_no_we", bus.mem_we, 0);
      idle(1);
      chk("pulse_done",  bus.done, 0);
      chk("pulse_error", bus.error, 0);
      chk("code_hold",   bus.err_code, bad ? 1 : 0);
      chk("wr_count",    we_count - w0, len);
   endtask

   initial begin
      logic [7:0]  b;
      logic [15:0] base;
      int          len, w0;
      bit          bad;

      bus.rx_dv   = 1'b0;
      bus.rx_byte = 8'h00;
      idle(3);
      chk("rst_addr",  bus.mem_addr, 0);
      chk("rst_data",  bus.mem_data, 0);
      chk("rst_we",    bus.mem_we, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_code",  bus.err_code, 0);
      rst_n = 1'b1;
      idle(2);

      // Good frame, then bad checksum, then good frame clears the status
      pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
      send_frame(16'h0200, 3, 1'b0);
      send_frame(16'h0200, 3, 1'b1);
      send_frame(16'h0200, 3, 1'b0);

      // Address wrap
      pl[0] = 8'h11; pl[1] = 8'h22;
      send_frame(16'hFFFF, 2, 1'b0);

      // Maximum length
      for (int i = 0; i < 256; i++) pl[i] = 8'(i);
      send_frame(16'h3000, 256, 1'b0);

      // Timeout in ADDR_LO
      w0 = we_count;
      send_byte(SYNC);
      send_byte(8'h02);
      idle(TMO - 1);
      chk("tmo_pre_busy",  bus.busy, 1);
      chk("tmo_pre_error", bus.error, 0);
      idle(1);
      chk("tmo_error", bus.error, 1);
      chk("tmo_code",  bus.err_code, 2);
      chk("tmo_busy",  bus.busy, 0);
      idle(1);
      chk("tmo_pulse", bus.error, 0);
      chk("tmo_hold",  bus.err_code, 2);
      pl[0] = 8'h00; pl[1] = 8'hAA; pl[2] = 8'h13;
      for (int i = 0; i < 3; i++) begin
         send_byte(pl[i]);
         chk("noise_busy",  bus.busy, 0);
         chk("noise_done",  bus.done, 0);
         chk("noise_error", bus.error, 0);
         chk("noise_code",  bus.err_code, 2);
      end
      chk("tmo_no_we", we_count - w0, 0);

      // A byte on the terminal-count cycle keeps the frame alive
      send_byte(SYNC);
      send_byte(8'h02);
      idle(TMO - 2);
      send_byte(8'h00);
      chk("term_error", bus.error, 0);
      chk("term_busy",  bus.busy, 1);
      send_byte(8'h01);
      send_byte(8'h7E);
      chk("term_we",   bus.mem_we, 1);
      chk("term_addr", bus.mem_addr, 16'h0200);
      chk("term_data", bus.mem_data, 8'h7E);
      send_byte(8'h7F);
      chk("term_done", bus.done, 1);
      chk("term_code", bus.err_code, 0);

      // Randomized frames separated by non-SYNC noise
      for (int f = 0; f < 8; f++) begin
         b = 8'($urandom);
         if (b == SYNC) b = 8'h00;
         send_byte(b);
         chk("rnd_noise_busy", bus.busy, 0);
         base = 16'($urandom);
         len  = $urandom_range(1, 24);
         bad  = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
         send_frame(base, len, bad);
      end

      // Asynchronous reset after the second data byte
      send_byte(SYNC);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("pre_rst_we", bus.mem_we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we",    bus.mem_we, 0);
      chk("arst_addr",  bus.mem_addr, 0);
      chk("arst_data",  bus.mem_data, 0);
      chk("arst_busy",  bus.busy, 0);
      chk("arst_done",  bus.done, 0);
      chk("arst_error", bus.error, 0);
      chk("arst_code",  bus.err_code, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      chk("post_rst_done",  bus.done, 0);
      chk("post_rst_error", bus.error, 0);
      chk("post_rst_busy",  bus.busy, 0);
      pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
      send_frame(16'h0200, 3, 1'b0);

      chk("done_error_overlap", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
